mxv_frame_ctrl: RTL and testbench
=================================

MXV_FRAME_CTRL -- requirements
Module: mxv_frame_ctrl

Interface
REQ-001 Parameter: NMAX, default 8; maximum matrix dimension and number of row FIFOs.
REQ-002 Parameter: DIW, default 8; width of payload data pushed to the FIFOs.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 tok_i  in  9  decoded frame token.
REQ-007 tok_vld_i  in  1  tok_i valid for one cycle; always accepted, no backpressure.
REQ-008 busy_i  in  1  multiply datapath running.
REQ-009 data_o  out  DIW  payload value that accompanies the push strobes.
REQ-010 mat_push_o  out  NMAX  one-hot push to row FIFO r.
REQ-011 vec_push_o  out  1  push to vector FIFO.
REQ-012 n_o  out  4  active matrix size, range 1..NMAX.
REQ-013 start_o  out  1  one-cycle start pulse to the datapath.
REQ-014 clean_o  out  1  one-cycle flush pulse to all matrix and vector FIFOs.
REQ-015 err_o  out  1  one-cycle frame-error pulse.

Function
REQ-016 Frame format: 0x0FE, 0x123, LEN, 0x123, CMD, 0x123, then per payload value: V, 0x123; frame ends with 0x0EF.
REQ-017 States: IDLE, UC1, LEN, UC2, CMD, UC3, PAY, UCP, EF, EXEC; IDLE waits for 0x0FE and ignores all other tokens silently.
REQ-018 Each valid token advances the FSM by exactly one state in the REQ-016 order.
REQ-019 From UC3 or UCP: if the remaining payload count is 0, go to EF; otherwise go to PAY.
REQ-020 Expected LEN per command: 0x001 SIZE = 1; 0x002 REPEAT = 0; 0x003 START = 0; 0x004 MV = n_o*n_o+n_o.
REQ-021 In state CMD, an unknown command or a LEN mismatch is an error.
REQ-022 Payload token with bit 8 set is an error.
REQ-023 SIZE payload outside 1..NMAX is an error.
REQ-024 Any token other than the one expected in the current non-IDLE state is an error.
REQ-025 On error: err_o pulses 1 cycle after the offending token; FSM returns to IDLE; clean_o pulses in the same cycle if any push occurred in the current frame.
REQ-026 MV payload is row-major; value k < n*n goes to row FIFO k/n, values k >= n*n go to the vector FIFO.
REQ-027 MV routing uses row/column counters; no divider.
REQ-028 Push strobe and data_o are registered and appear 1 cycle after the payload token.
REQ-029 On EF acceptance the FSM enters EXEC for one cycle and then returns to IDLE.
REQ-030 EXEC action for SIZE: n_o updates; clean_o pulses.
REQ-031 EXEC action for MV: loaded flag sets; start_o pulses.
REQ-032 EXEC action for START and REPEAT: start_o pulses only if the loaded flag is set.
REQ-033 EXEC action for START: clears the loaded flag after issuing start_o.
REQ-034 EXEC action for REPEAT: keeps the loaded flag.
REQ-035 start_o and clean_o are asserted in the cycle after EXEC, i.e. 2 cycles after the EF token.
REQ-036 Error in EXEC if busy_i=1 when start_o would fire; start_o is then suppressed and err_o pulses.
REQ-037 Error in EXEC if START or REPEAT arrives with the loaded flag clear.
REQ-038 0x0FE received mid-frame is an error.
REQ-039 No resynchronisation on 0x0FE mid-frame: the next frame starts only at a subsequent 0x0FE.

Reset
REQ-040 Reset state: FSM=IDLE, n_o=NMAX, loaded=0, counters=0.
REQ-041 Reset values: data_o=0, mat_push_o=0, vec_push_o=0, start_o=0, clean_o=0, err_o=0.
REQ-042 Reset asserted mid-frame discards the partial frame.
REQ-043 No outputs pulse on reset release.

Configuration
REQ-044 Macro MXV_FRAME_ERR_CNT_EN defined: adds output err_cnt_o  out  8, a saturating count of err_o pulses (sticks at 255), cleared by reset.
REQ-045 Macro MXV_FRAME_ERR_CNT_EN undefined: port err_cnt_o and its counter are absent; all other behaviour is identical.

Verification
REQ-046 Frame FE,_,1,_,1,_,3,_,EF -> n_o=3 and clean_o pulses 2 cycles after EF; no err_o.
REQ-047 With n=2, MV frame LEN=6, values 1..6 -> pushes row0 1,2; row1 3,4; vector 5,6; start_o pulses once; busy_i=0.
REQ-048 MV frame with LEN=5 at n=2 -> err_o 1 cycle after CMD token; no pushes; FSM back in IDLE.
REQ-049 Payload token 0x1AA after two MV pushes -> err_o and clean_o in the same cycle; following valid frame processed normally.
REQ-050 REPEAT with busy_i=1 after a loaded MV -> no start_o; err_o pulses; REPEAT repeated with busy_i=0 -> start_o.
REQ-051 rst_n low mid-MV payload, then START frame -> err_o (loaded=0); with MXV_FRAME_ERR_CNT_EN, err_cnt_o=1.

Source files
------------

// File: rtl/mxv_frame_ctrl.sv
// Frame decoder for the matrix-vector unit; routes payload into row/vector FIFOs.
// MXV_FRAME_ERR_CNT_EN adds a saturating error counter output (err_cnt_o).
module mxv_frame_ctrl #(
    parameter int NMAX = 8,
    parameter int DIW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [8:0]      tok_i,
    input  logic            tok_vld_i,
    input  logic            busy_i,
    output logic [DIW-1:0]  data_o,
    output logic [NMAX-1:0] mat_push_o,
    output logic            vec_push_o,
    output logic [3:0]      n_o,
    output logic            start_o,
    output logic            clean_o,
    output logic            err_o
`ifdef MXV_FRAME_ERR_CNT_EN
    ,
    output logic [7:0]      err_cnt_o
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_UC1, S_LEN, S_UC2, S_CMD,
        S_UC3, S_PAY, S_UCP, S_EF, S_EXEC
    } state_t;

    localparam logic [8:0] TOK_SOF = 9'h0FE;
    localparam logic [8:0] TOK_UC  = 9'h123;
    localparam logic [8:0] TOK_EOF = 9'h0EF;
    localparam logic [2:0] C_SIZE  = 3'd1;
    localparam logic [2:0] C_REP   = 3'd2;
    localparam logic [2:0] C_START = 3'd3;
    localparam logic [2:0] C_MV    = 3'd4;

    state_t          state_q, state_nx;
    logic [8:0]      len_q, len_nx;
    logic [8:0]      rem_q, rem_nx;
    logic [2:0]      cmd_q, cmd_nx;
    logic [3:0]      row_q, row_nx;
    logic [3:0]      col_q, col_nx;
    logic [3:0]      size_q, size_nx;
    logic            pushed_q, pushed_nx;
    logic            loaded_q, loaded_nx;
    logic [3:0]      n_nx;
    logic [DIW-1:0]  data_nx;
    logic [NMAX-1:0] mat_nx;
    logic            vec_nx, start_nx, clean_nx, err_nx;
    logic            bad;
    logic            is_sof, is_uc, is_eof;
    logic [8:0]      exp_len;
    logic [8:0]      n_ext;
    logic [NMAX-1:0] row_one;

    assign is_sof  = (tok_i == TOK_SOF);
    assign is_uc   = (tok_i == TOK_UC);
    assign is_eof  = (tok_i == TOK_EOF);
    assign n_ext   = {5'd0, n_o};
    assign row_one = {{(NMAX-1){1'b0}}, 1'b1};

    always_comb begin
        exp_len = 9'h1FF;
        unique case (1'b1)
            tok_i == {6'd0, C_SIZE}:  exp_len = 9'd1;
            tok_i == {6'd0, C_REP}:   exp_len = 9'd0;
            tok_i == {6'd0, C_START}: exp_len = 9'd0;
            tok_i == {6'd0, C_MV}:    exp_len = n_ext * n_ext + n_ext;
            default:                  exp_len = 9'h1FF;
        endcase
    end

    always_comb begin
        state_nx  = state_q;
        len_nx    = len_q;
        rem_nx    = rem_q;
        cmd_nx    = cmd_q;
        row_nx    = row_q;
        col_nx    = col_q;
        size_nx   = size_q;
        pushed_nx = pushed_q;
        loaded_nx = loaded_q;
        n_nx      = n_o;
        data_nx   = data_o;
        mat_nx    = '0;
        vec_nx    = 1'b0;
        start_nx  = 1'b0;
        clean_nx  = 1'b0;
        err_nx    = 1'b0;
        bad       = 1'b0;
        if (state_q == S_EXEC) begin
            state_nx  = S_IDLE;
            pushed_nx = 1'b0;
            unique case (1'b1)
                cmd_q == C_SIZE: begin
                    n_nx      = size_q;
                    clean_nx  = 1'b1;
                    loaded_nx = 1'b0;
                end
                cmd_q == C_MV: begin
                    if (busy_i) begin
                        err_nx    = 1'b1;
                        clean_nx  = pushed_q;
                        loaded_nx = 1'b0;
                    end else begin
                        start_nx  = 1'b1;
                        loaded_nx = 1'b1;
                    end
                end
                cmd_q == C_REP || cmd_q == C_START: begin
                    if (!loaded_q || busy_i) begin
                        err_nx = 1'b1;
                    end else begin
                        start_nx = 1'b1;
                        if (cmd_q == C_START) loaded_nx = 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (tok_vld_i) begin
            unique case (state_q)
                S_IDLE: if (is_sof) begin
                    state_nx  = S_UC1;
                    rem_nx    = '0;
                    row_nx    = '0;
                    col_nx    = '0;
                    pushed_nx = 1'b0;
                end
                S_UC1: if (is_uc) state_nx = S_LEN; else bad = 1'b1;
                S_LEN: begin
                    if (is_sof) bad = 1'b1;
                    len_nx   = tok_i;
                    state_nx = S_UC2;
                end
                S_UC2: if (is_uc) state_nx = S_CMD; else bad = 1'b1;
                S_CMD: begin
                    if (is_sof || exp_len != len_q) begin
                        bad = 1'b1;
                    end else begin
                        cmd_nx   = tok_i[2:0];
                        rem_nx   = len_q;
                        state_nx = S_UC3;
                    end
                end
                S_UC3, S_UCP: begin
                    if (!is_uc) bad = 1'b1;
                    else state_nx = (rem_q == '0) ? S_EF : S_PAY;
                end
                S_PAY: begin
                    if (is_sof || tok_i[8]) begin
                        bad = 1'b1;
                    end else if (cmd_q == C_SIZE &&
                                 (tok_i[7:0] == 8'd0 ||
                                  tok_i[7:0] > 8'(NMAX))) begin
                        bad = 1'b1;
                    end else begin
                        rem_nx   = rem_q - 9'd1;
                        state_nx = S_UCP;
                        if (cmd_q == C_SIZE) size_nx = tok_i[3:0];
                        if (cmd_q == C_MV) begin
                            pushed_nx = 1'b1;
                            data_nx   = DIW'(tok_i[7:0]);
                            // row_q == n means the matrix part is done
                            if (row_q == n_o) begin
                                vec_nx = 1'b1;
                            end else begin
                                mat_nx = row_one << row_q;
                                if (col_q == n_o - 4'd1) begin
                                    col_nx = '0;
                                    row_nx = row_q + 4'd1;
                                end else begin
                                    col_nx = col_q + 4'd1;
                                end
                            end
                        end
                    end
                end
                S_EF: if (is_eof) state_nx = S_EXEC; else bad = 1'b1;
                default: state_nx = S_IDLE;
            endcase
            if (bad) begin
                err_nx    = 1'b1;
                clean_nx  = pushed_q;
                pushed_nx = 1'b0;
                state_nx  = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            rem_q      <= '0;
            cmd_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            size_q     <= '0;
            pushed_q   <= 1'b0;
            loaded_q   <= 1'b0;
            n_o        <= 4'(NMAX);
            data_o     <= '0;
            mat_push_o <= '0;
            vec_push_o <= 1'b0;
            start_o    <= 1'b0;
            clean_o    <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            len_q      <= len_nx;
            rem_q      <= rem_nx;
            cmd_q      <= cmd_nx;
            row_q      <= row_nx;
            col_q      <= col_nx;
            size_q     <= size_nx;
            pushed_q   <= pushed_nx;
            loaded_q   <= loaded_nx;
            n_o        <= n_nx;
            data_o     <= data_nx;
            mat_push_o <= mat_nx;
            vec_push_o <= vec_nx;
            start_o    <= start_nx;
            clean_o    <= clean_nx;
            err_o      <= err_nx;
        end
    end

`ifdef MXV_FRAME_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           err_cnt_o <= '0;
        else if (err_nx && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
    end
`endif

endmodule

// File: tb/tb_mxv_frame_ctrl.sv
// Directed self-checking bench for mxv_frame_ctrl (NMAX=8, DIW=8).
// Tokens are driven on the falling edge; outputs are checked on falling edges.
module tb_mxv_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] tok_i = '0;
    logic       tok_vld_i = 1'b0;
    logic       busy_i = 1'b0;
    logic [7:0] data_o;
    logic [7:0] mat_push_o;
    logic       vec_push_o;
    logic [3:0] n_o;
    logic       start_o, clean_o, err_o;
`ifdef MXV_FRAME_ERR_CNT_EN
    logic [7:0] err_cnt_o;
`endif

    int tests = 0;
    int fails = 0;

    mxv_frame_ctrl #(.NMAX(8), .DIW(8)) dut (
        .clk(clk), .rst_n(rst_n), .tok_i(tok_i), .tok_vld_i(tok_vld_i),
        .busy_i(busy_i), .data_o(data_o), .mat_push_o(mat_push_o),
        .vec_push_o(vec_push_o), .n_o(n_o), .start_o(start_o),
        .clean_o(clean_o), .err_o(err_o)
`ifdef MXV_FRAME_ERR_CNT_EN
        , .err_cnt_o(err_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one token for one cycle; return on the next falling edge,
    // where registered responses to that token are visible.
    task automatic send(input logic [8:0] v);
        @(negedge clk);
        tok_i = v;
        tok_vld_i = 1'b1;
        @(negedge clk);
        tok_vld_i = 1'b0;
    endtask

    task automatic hdr(input logic [8:0] len, input logic [8:0] cmd);
        send(9'h0FE);
        send(9'h123);
        send(len);
        send(9'h123);
        send(cmd);
    endtask

    // exp = {start, clean, err} expected two cycles after EF.
    task automatic end_frame(input string tag, input logic [2:0] exp);
        send(9'h0EF);
        chk({tag, "_gap"}, {start_o, clean_o, err_o}, 3'b000);
        @(negedge clk);
        chk(tag, {start_o, clean_o, err_o}, exp);
        @(negedge clk);
        chk({tag, "_end"}, {start_o, clean_o, err_o}, 3'b000);
    endtask

    task automatic size_frame(input logic [8:0] v);
        hdr(9'd1, 9'd1);
        send(9'h123);
        send(v);
        chk("size_nopush", {mat_push_o, vec_push_o}, 9'd0);
        send(9'h123);
        end_frame("size_exec", 3'b010);
    endtask

    task automatic mv_frame(input int n, input logic [7:0] base);
        logic [7:0] em;
        hdr(9'(n * n + n), 9'd4);
        send(9'h123);
        for (int k = 0; k < n * n + n; k++) begin
            send({1'b0, base + 8'(k)});
            em = (k < n * n) ? (8'd1 << (k / n)) : 8'd0;
            chk($sformatf("mv_push_k%0d", k),
                {mat_push_o, vec_push_o, data_o},
                {em, (k >= n * n) ? 1'b1 : 1'b0, base + 8'(k)});
            send(9'h123);
        end
        end_frame("mv_exec", 3'b100);
    endtask

    initial begin
        // reset values
        repeat (2) @(negedge clk);
        chk("rst_n_o", n_o, 4'd8);
        chk("rst_data", data_o, 8'd0);
        chk("rst_push", {mat_push_o, vec_push_o}, 9'd0);
        chk("rst_pulses", {start_o, clean_o, err_o}, 3'b000);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rel_pulses", {start_o, clean_o, err_o}, 3'b000);

        // SIZE 3, then SIZE 2
        size_frame(9'd3);
        chk("size3_n", n_o, 4'd3);
        size_frame(9'd2);
        chk("size2_n", n_o, 4'd2);

        // MV at n=2, values 1..6
        mv_frame(2, 8'd1);

        // MV with wrong LEN: error right after CMD
        hdr(9'd5, 9'd4);
        chk("len_bad_err", {start_o, clean_o, err_o}, 3'b001);
        chk("len_bad_push", {mat_push_o, vec_push_o}, 9'd0);
        send(9'h123);
        chk("len_bad_idle", {start_o, clean_o, err_o}, 3'b000);

        // REPEAT while busy, then REPEAT idle
        busy_i = 1'b1;
        hdr(9'd0, 9'd2);
        send(9'h123);
        end_frame("rep_busy", 3'b001);
        busy_i = 1'b0;
        hdr(9'd0, 9'd2);
        send(9'h123);
        end_frame("rep_ok", 3'b100);

        // START consumes the loaded flag
        hdr(9'd0, 9'd3);
        send(9'h123);
        end_frame("start_ok", 3'b100);
        hdr(9'd0, 9'd3);
        send(9'h123);
        end_frame("start_unloaded", 3'b001);

        // bad payload after two pushes, then recovery
        hdr(9'd6, 9'd4);
        send(9'h123);
        send(9'h00A);
        chk("p1_push", {mat_push_o, data_o}, {8'h01, 8'h0A});
        send(9'h123);
        send(9'h00B);
        send(9'h123);
        send(9'h1AA);
        chk("bit8_err", {start_o, clean_o, err_o}, 3'b011);
        mv_frame(2, 8'h20);

        // SOF mid-frame: error, no resync on that SOF
        send(9'h0FE);
        send(9'h123);
        send(9'h0FE);
        chk("sof_mid_err", {start_o, clean_o, err_o}, 3'b001);
        send(9'h123);
        chk("sof_noresync", {start_o, clean_o, err_o}, 3'b000);
        size_frame(9'd4);
        chk("size4_n", n_o, 4'd4);

        // SIZE out of range, unknown command, wrong terminator
        hdr(9'd1, 9'd1);
        send(9'h123);
        send(9'd9);
        chk("size9_err", {start_o, clean_o, err_o}, 3'b001);
        hdr(9'd1, 9'd1);
        send(9'h123);
        send(9'd0);
        chk("size0_err", {start_o, clean_o, err_o}, 3'b001);
        chk("size_keep_n", n_o, 4'd4);
        hdr(9'd0, 9'd5);
        chk("cmd5_err", {start_o, clean_o, err_o}, 3'b001);
        hdr(9'd0, 9'd2);
        send(9'h123);
        send(9'h0EE);
        chk("eof_bad_err", {start_o, clean_o, err_o}, 3'b001);

        // reset mid-MV payload, then START with nothing loaded
        hdr(9'd20, 9'd4);
        send(9'h123);
        send(9'd1);
        send(9'h123);
        send(9'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_n", n_o, 4'd8);
        chk("mid_rst_out", {mat_push_o, vec_push_o, data_o}, 17'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rel", {start_o, clean_o, err_o}, 3'b000);
        hdr(9'd0, 9'd3);
        send(9'h123);
        end_frame("rst_start", 3'b001);
`ifdef MXV_FRAME_ERR_CNT_EN
        chk("err_cnt", err_cnt_o, 8'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
